// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART core (one transmitter, one receiver).
//
// Parameters
//   DATA_WIDTH   data bits per frame (5..9)
//   CLKS_PER_BIT clk cycles per bit period (>=4, even)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    stop bits per frame (1 or 2)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   enable        TX request, accepted when high and o_busy low
//   i_data        TX payload, captured on the acceptance cycle
//   o_busy        TX frame in progress
//   serial_out    TX line, idle high
//   serial_in     RX line, asynchronous to clk
//   received_data last received payload (updated on good and bad frames)
//   data_is_valid one-cycle pulse, good frame received
//   rx_error      one-cycle pulse, bad frame received
//   parity_err    parity mismatch, meaningful only while rx_error is high
//   frame_err     a stop bit sampled low, meaningful only while rx_error is high
module uart_param #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_busy,
  output logic                  serial_out,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  data_is_valid,
  output logic                  rx_error,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] BaudHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]      BitLast  = 4'(DATA_WIDTH - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);
  localparam bit              HasParity = (PARITY_MODE != 0);
  localparam bit              OddParity = (PARITY_MODE == 2);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxDone} rx_state_e;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e             tx_state_q;
  logic [CntW-1:0]       tx_baud_q;
  logic [3:0]            tx_bit_q;
  logic                  tx_stop_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic                  tx_par_q;
  logic                  serial_out_q;
  logic                  busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q   <= TxIdle;
      tx_baud_q    <= '0;
      tx_bit_q     <= '0;
      tx_stop_q    <= 1'b0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      serial_out_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          if (enable) begin
            tx_shift_q   <= i_data;
            tx_par_q     <= (^i_data) ^ OddParity;
            tx_baud_q    <= '0;
            tx_bit_q     <= '0;
            tx_stop_q    <= 1'b0;
            serial_out_q <= 1'b0;
            busy_q       <= 1'b1;
            tx_state_q   <= TxStart;
          end
        end
        TxStart: begin
          if (tx_baud_q == BaudLast) begin
            tx_baud_q    <= '0;
            serial_out_q <= tx_shift_q[0];
            tx_shift_q   <= tx_shift_q >> 1;
            tx_state_q   <= TxData;
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
        TxData: begin
          if (tx_baud_q == BaudLast) begin
            tx_baud_q <= '0;
            if (tx_bit_q == BitLast) begin
              if (HasParity) begin
                serial_out_q <= tx_par_q;
                tx_state_q   <= TxParity;
              end else begin
                serial_out_q <= 1'b1;
                tx_state_q   <= TxStop;
              end
            end else begin
              tx_bit_q     <= tx_bit_q + 4'd1;
              serial_out_q <= tx_shift_q[0];
              tx_shift_q   <= tx_shift_q >> 1;
            end
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
        TxParity: begin
          if (tx_baud_q == BaudLast) begin
            tx_baud_q    <= '0;
            serial_out_q <= 1'b1;
            tx_state_q   <= TxStop;
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
        TxStop: begin
          if (tx_baud_q == BaudLast) begin
            tx_baud_q <= '0;
            if (tx_stop_q == StopLast) begin
              busy_q     <= 1'b0;
              tx_state_q <= TxIdle;
            end else begin
              tx_stop_q <= tx_stop_q + 1'b1;
            end
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign serial_out = serial_out_q;
  assign o_busy     = busy_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  rx_state_e             rx_state_q;
  logic                  rx_sync1_q;
  logic                  rx_sync2_q;
  logic                  rx_prev_q;
  logic [CntW-1:0]       rx_baud_q;
  logic [3:0]            rx_bit_q;
  logic                  rx_stop_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic                  rx_par_bad_q;
  logic                  rx_frame_bad_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  rx_err_q;
  logic                  rx_perr_q;
  logic                  rx_ferr_q;
  logic                  rx_stop_bad;

  // Sticky across both stop bits so any low stop sample is reported.
  assign rx_stop_bad = rx_frame_bad_q | ~rx_sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q     <= RxIdle;
      rx_sync1_q     <= 1'b1;
      rx_sync2_q     <= 1'b1;
      rx_prev_q      <= 1'b1;
      rx_baud_q      <= '0;
      rx_bit_q       <= '0;
      rx_stop_q      <= 1'b0;
      rx_shift_q     <= '0;
      rx_par_bad_q   <= 1'b0;
      rx_frame_bad_q <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_err_q       <= 1'b0;
      rx_perr_q      <= 1'b0;
      rx_ferr_q      <= 1'b0;
    end else begin
      rx_sync1_q <= serial_in;
      rx_sync2_q <= rx_sync1_q;
      // prev tracks the line in every state, so a held-low line never looks
      // like a fresh falling edge once the receiver returns to idle.
      rx_prev_q  <= rx_sync2_q;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;

      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync2_q) begin
            rx_baud_q  <= '0;
            rx_state_q <= RxStart;
          end
        end
        RxStart: begin
          if (rx_baud_q == BaudHalf) begin
            rx_baud_q <= '0;
            if (rx_sync2_q) begin
              rx_state_q <= RxIdle;  // glitch: line back high at mid start bit
            end else begin
              rx_bit_q       <= '0;
              rx_par_bad_q   <= 1'b0;
              rx_frame_bad_q <= 1'b0;
              rx_state_q     <= RxData;
            end
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        RxData: begin
          if (rx_baud_q == BaudLast) begin
            rx_baud_q  <= '0;
            rx_shift_q <= {rx_sync2_q, rx_shift_q[DATA_WIDTH-1:1]};
            if (rx_bit_q == BitLast) begin
              rx_stop_q  <= 1'b0;
              rx_state_q <= HasParity ? RxParity : RxStop;
            end else begin
              rx_bit_q <= rx_bit_q + 4'd1;
            end
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        RxParity: begin
          if (rx_baud_q == BaudLast) begin
            rx_baud_q    <= '0;
            rx_par_bad_q <= rx_sync2_q ^ (^rx_shift_q) ^ OddParity;
            rx_state_q   <= RxStop;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        RxStop: begin
          if (rx_baud_q == BaudLast) begin
            rx_baud_q <= '0;
            if (rx_stop_q == StopLast) begin
              // Result registers load here so the pulses coincide with Done.
              rx_data_q  <= rx_shift_q;
              rx_state_q <= RxDone;
              if (rx_par_bad_q || rx_stop_bad) begin
                rx_err_q  <= 1'b1;
                rx_perr_q <= rx_par_bad_q;
                rx_ferr_q <= rx_stop_bad;
              end else begin
                rx_valid_q <= 1'b1;
              end
            end else begin
              rx_stop_q      <= rx_stop_q + 1'b1;
              rx_frame_bad_q <= rx_stop_bad;
            end
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        RxDone:  rx_state_q <= RxIdle;
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  assign received_data = rx_data_q;
  assign data_is_valid = rx_valid_q;
  assign rx_error      = rx_err_q;
  assign parity_err    = rx_perr_q;
  assign frame_err     = rx_ferr_q;

endmodule
